// File: rtl/size_count_pkg.sv
// Shared state encoding and parameter defaults for the queued transfer-size counter.
package size_count_pkg;

    localparam int CW_DEFAULT    = 32;
    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        COUNT = 2'b11
    } state_e;

endpackage

// File: rtl/size_count_q_fifo.sv
// Size queue: array storage with a registered head read, so a freshly written head
// becomes usable one cycle after it lands in the array.
module size_fifo
    import size_count_pkg::*;
#(
    parameter int CW    = CW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic [CW-1:0]              push_data,
    input  logic                       pop,
    output logic [CW-1:0]              head,
    output logic                       head_valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 1);

    logic [CW-1:0] mem_q [DEPTH];
    logic [CW-1:0] head_q;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          head_valid_q, head_valid_d;
    logic          do_push, do_pop;

    assign full       = (count_q == PW'(DEPTH));
    assign count      = count_q;
    assign head       = head_q;
    assign head_valid = head_valid_q;

    always_comb begin
        do_push = push && !full && !clear;
        do_pop  = pop && head_valid_q && !clear;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + AW'(do_push);
            rd_ptr_d = rd_ptr_q + AW'(do_pop);
            count_d  = count_q + PW'(do_push) - PW'(do_pop);
        end
        // Head read this edge sees the old array contents, so a write into the head slot is not yet visible.
        head_valid_d = (count_d != '0) && !(do_push && (wr_ptr_q == rd_ptr_d));
    end

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
        head_q <= mem_q[rd_ptr_d];
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
        end
    end

endmodule

// File: rtl/size_count_q.sv
// Queued beat counter: loads transfer sizes from the size queue, counts data beats
// down to the final one and chains queued transfers without an idle gap.
module size_count_q
    import size_count_pkg::*;
#(
    parameter int CW    = CW_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       size_valid,
    output logic                       size_ready,
    input  logic [CW-1:0]              size,
    input  logic                       data_start,
    input  logic                       data_valid,
    output logic                       last,
    output logic                       retreiving,
    output logic [CW-1:0]              current,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       zero_drop
);

    localparam int PW = $clog2(DEPTH + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] current_q, current_d;
    logic          zero_drop_q, zero_drop_d;

    logic          full, head_valid, pop, accept, push;
    logic [CW-1:0] head;
    logic [PW-1:0] count;
    logic          load_cnt, dec_cnt, clr_cnt, cnt_one;

    size_fifo #(
        .CW    (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .rst_n      (rst_n),
        .clear      (flush),
        .push       (push),
        .push_data  (size),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .full       (full),
        .count      (count)
    );

    // Zero-length sizes are consumed at the port but never reach the queue.
    assign size_ready  = !full;
    assign accept      = size_valid && size_ready && !flush;
    assign push        = accept && (size != '0);
    assign zero_drop_d = accept && (size == '0);

    assign cnt_one    = (current_q == CW'(1));
    assign current    = current_q;
    assign busy       = (state_q != IDLE);
    assign pending    = count;
    assign zero_drop  = zero_drop_q;

    // Controller
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        load_cnt   = 1'b0;
        dec_cnt    = 1'b0;
        clr_cnt    = 1'b0;
        last       = 1'b0;
        retreiving = 1'b0;
        if (flush) begin
            state_d = IDLE;
            clr_cnt = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (head_valid) begin
                        pop      = 1'b1;
                        load_cnt = 1'b1;
                        state_d  = ARMED;
                    end
                end
                ARMED: begin
                    if (data_start) begin
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    if (data_valid) begin
                        if (cnt_one) begin
                            last = 1'b1;
                            if (head_valid) begin
                                pop      = 1'b1;
                                load_cnt = 1'b1;
                                state_d  = ARMED;
                            end else begin
                                clr_cnt = 1'b1;
                                state_d = IDLE;
                            end
                        end else begin
                            retreiving = 1'b1;
                            dec_cnt    = 1'b1;
                        end
                    end
                end
                default: begin
                    clr_cnt = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Datapath
    always_comb begin
        current_d = current_q;
        if (clr_cnt) begin
            current_d = '0;
        end else if (load_cnt) begin
            current_d = head;
        end else if (dec_cnt) begin
            current_d = current_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            current_q   <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            current_q   <= current_d;
            zero_drop_q <= zero_drop_d;
        end
    end

endmodule

// File: tb/tb_size_count_q.sv
// Bench for size_count_q: fixed vector table, hand-written corner sequences and a
// randomized run, all cross-checked against a queue-based reference model.
module tb_size_count_q;

    localparam int CW    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = $clog2(DEPTH + 1);

    logic          clock = 1'b0;
    logic          rst_n;
    logic          flush, size_valid, data_start, data_valid;
    logic [CW-1:0] size;
    logic          size_ready, last, retreiving, busy, zero_drop;
    logic [CW-1:0] current;
    logic [PW-1:0] pending;

    size_count_q #(.CW(CW), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .flush      (flush),
        .size_valid (size_valid),
        .size_ready (size_ready),
        .size       (size),
        .data_start (data_start),
        .data_valid (data_valid),
        .last       (last),
        .retreiving (retreiving),
        .current    (current),
        .busy       (busy),
        .pending    (pending),
        .zero_drop  (zero_drop)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Reference model: queued sizes with the cycle from which each may be loaded,
    // plus whether a transfer is loaded, whether its data has started, and beats left.
    typedef struct {
        int sz;
        int avail;
    } qe_t;
    qe_t mq[$];
    bit  m_loaded, m_started, m_zd;
    int  m_rem;
    int  cyc;

    typedef struct {
        bit f, sv; int sz; bit ds, dv;
        bit e_last, e_ret; int e_cur; bit e_busy; int e_pend; bit e_zd;
    } vec_t;
    vec_t tbl [27];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_loaded  = 1'b0;
        m_started = 1'b0;
        m_rem     = 0;
        m_zd      = 1'b0;
    endtask

    task automatic drive(input bit f, input bit sv, input int sz, input bit ds, input bit dv);
        flush      = f;
        size_valid = sv;
        size       = CW'(sz);
        data_start = ds;
        data_valid = dv;
        #1;
    endtask

    task automatic check_model(input string tag);
        bit counting, beat;
        counting = m_loaded && m_started;
        beat     = !flush && counting && data_valid;
        check({tag, "_last"},    last,       beat && (m_rem == 1));
        check({tag, "_retr"},    retreiving, beat && (m_rem != 1));
        check({tag, "_cur"},     current,    m_rem);
        check({tag, "_busy"},    busy,       m_loaded);
        check({tag, "_pend"},    pending,    mq.size());
        check({tag, "_ready"},   size_ready, mq.size() < DEPTH);
        check({tag, "_zd"},      zero_drop,  m_zd);
    endtask

    task automatic advance();
        bit  acc, avail, do_load;
        qe_t e;
        if (flush) begin
            model_reset();
        end else begin
            acc     = size_valid && (mq.size() < DEPTH);
            avail   = (mq.size() > 0) && (mq[0].avail <= cyc);
            do_load = 1'b0;
            if (!m_loaded) begin
                do_load = avail;
            end else if (!m_started) begin
                if (data_start) m_started = 1'b1;
            end else if (data_valid) begin
                if (m_rem == 1) begin
                    if (avail) begin
                        do_load = 1'b1;
                    end else begin
                        m_loaded = 1'b0;
                        m_rem    = 0;
                    end
                end else begin
                    m_rem--;
                end
            end
            if (do_load) begin
                m_rem     = mq[0].sz;
                m_loaded  = 1'b1;
                m_started = 1'b0;
                void'(mq.pop_front());
            end
            if (acc && (size != '0)) begin
                e.sz    = int'(size);
                e.avail = cyc + 2;
                mq.push_back(e);
            end
            m_zd = acc && (size == '0);
        end
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic step(input bit f, input bit sv, input int sz, input bit ds, input bit dv, input string tag);
        drive(f, sv, sz, ds, dv);
        check_model(tag);
        advance();
    endtask

    initial begin
        bit   pat5 [7];
        int   cur5 [7];
        bit   r_f, r_sv, r_ds, r_dv;
        int   r_sz;

        tbl = '{
            '{0,1,3,0,0, 0,0,0,0,0,0}, '{0,0,0,0,0, 0,0,0,0,1,0}, '{0,0,0,0,0, 0,0,0,0,1,0},
            '{0,0,0,1,0, 0,0,3,1,0,0}, '{0,0,0,0,1, 0,1,3,1,0,0}, '{0,0,0,0,1, 0,1,2,1,0,0},
            '{0,0,0,0,1, 1,0,1,1,0,0}, '{0,0,0,0,0, 0,0,0,0,0,0},
            '{0,1,0,0,0, 0,0,0,0,0,0}, '{0,1,1,0,0, 0,0,0,0,0,1}, '{0,0,0,0,0, 0,0,0,0,1,0},
            '{0,0,0,0,0, 0,0,0,0,1,0}, '{0,0,0,1,0, 0,0,1,1,0,0}, '{0,0,0,0,1, 1,0,1,1,0,0},
            '{0,0,0,0,0, 0,0,0,0,0,0},
            '{0,1,2,0,0, 0,0,0,0,0,0}, '{0,1,4,0,0, 0,0,0,0,1,0}, '{0,0,0,0,0, 0,0,0,0,2,0},
            '{0,0,0,1,0, 0,0,2,1,1,0}, '{0,0,0,0,1, 0,1,2,1,1,0}, '{0,0,0,0,1, 1,0,1,1,1,0},
            '{0,0,0,1,1, 0,0,4,1,0,0}, '{0,0,0,0,1, 0,1,4,1,0,0}, '{0,0,0,0,1, 0,1,3,1,0,0},
            '{0,0,0,0,1, 0,1,2,1,0,0}, '{0,0,0,0,1, 1,0,1,1,0,0}, '{0,0,0,0,0, 0,0,0,0,0,0}
        };
        pat5 = '{1, 0, 1, 0, 1, 1, 1};
        cur5 = '{5, 4, 4, 3, 3, 2, 1};

        rst_n = 1'b0;
        cyc   = 0;
        model_reset();
        drive(0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_cur",   current,    0);
        check("rst_busy",  busy,       0);
        check("rst_pend",  pending,    0);
        check("rst_ready", size_ready, 1);
        check("rst_zd",    zero_drop,  0);
        check("rst_last",  last,       0);
        rst_n = 1'b1;

        // Sizes 3; 0 then 1; 2 and 4 back-to-back
        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].f, tbl[i].sv, tbl[i].sz, tbl[i].ds, tbl[i].dv);
            check($sformatf("tbl%0d_last", i), last,       tbl[i].e_last);
            check($sformatf("tbl%0d_retr", i), retreiving, tbl[i].e_ret);
            check($sformatf("tbl%0d_cur", i),  current,    tbl[i].e_cur);
            check($sformatf("tbl%0d_busy", i), busy,       tbl[i].e_busy);
            check($sformatf("tbl%0d_pend", i), pending,    tbl[i].e_pend);
            check($sformatf("tbl%0d_zd", i),   zero_drop,  tbl[i].e_zd);
            check_model($sformatf("tbl%0d", i));
            advance();
        end

        // Fill: one loaded plus DEPTH queued, then the queue refuses
        for (int k = 0; k < DEPTH + 2; k++) begin
            drive(0, 1, 10 + k, 0, 0);
            check($sformatf("fill%0d_ready", k), size_ready, k <= DEPTH);
            check_model($sformatf("fill%0d", k));
            advance();
        end
        drive(0, 0, 0, 0, 0);
        check("fill_pend",  pending,    DEPTH);
        check("fill_ready", size_ready, 0);
        check("fill_cur",   current,    10);
        step(1, 1, 7, 0, 1, "fill_flush");
        drive(0, 0, 0, 0, 0);
        check("flush1_busy", busy, 0);
        check("flush1_pend", pending, 0);
        check("flush1_cur",  current, 0);
        check_model("flush1");
        advance();

        // Size 5 with gapped data_valid
        step(0, 1, 5, 0, 0, "gap_push");
        step(0, 0, 0, 0, 0, "gap_w0");
        step(0, 0, 0, 0, 0, "gap_w1");
        step(0, 0, 0, 1, 0, "gap_start");
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 0, pat5[i]);
            check($sformatf("gap%0d_cur", i),  current, cur5[i]);
            check($sformatf("gap%0d_last", i), last,    i == 6);
            check_model($sformatf("gap%0d", i));
            advance();
        end
        step(0, 0, 0, 0, 0, "gap_end");

        // Flush on the would-be last beat with two sizes queued
        step(0, 1, 2, 0, 0, "fl_p0");
        step(0, 1, 7, 0, 0, "fl_p1");
        step(0, 1, 8, 0, 0, "fl_p2");
        drive(0, 0, 0, 1, 0);
        check("fl_pend2", pending, 2);
        check_model("fl_start");
        advance();
        step(0, 0, 0, 0, 1, "fl_beat");
        drive(1, 0, 0, 0, 1);
        check("fl_last", last, 0);
        check("fl_retr", retreiving, 0);
        check_model("fl_cyc");
        advance();
        drive(0, 0, 0, 0, 0);
        check("fl_busy", busy, 0);
        check("fl_cur",  current, 0);
        check("fl_pend", pending, 0);
        check_model("fl_after");
        advance();

        // Asynchronous reset in the middle of counting
        step(0, 1, 9, 0, 0, "rs_p0");
        step(0, 1, 3, 0, 0, "rs_p1");
        step(0, 1, 3, 0, 0, "rs_p2");
        step(0, 0, 0, 1, 0, "rs_start");
        step(0, 0, 0, 0, 1, "rs_beat");
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 1);
        check("rs_busy",  busy,       0);
        check("rs_cur",   current,    0);
        check("rs_pend",  pending,    0);
        check("rs_last",  last,       0);
        check("rs_ready", size_ready, 1);
        model_reset();
        @(posedge clock);
        #1;
        cyc++;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, "rs_idle");

        // Maximum size counts every beat without wrapping
        step(0, 1, 255, 0, 0, "max_push");
        step(0, 0, 0, 0, 0, "max_w0");
        step(0, 0, 0, 0, 0, "max_w1");
        step(0, 0, 0, 1, 0, "max_start");
        check("max_cur", current, 255);
        for (int i = 0; i < 255; i++) begin
            drive(0, 0, 0, 0, 1);
            if (i == 254 || i == 0) begin
                check($sformatf("max%0d_last", i), last, i == 254);
            end
            check_model($sformatf("max%0d", i));
            advance();
        end
        step(0, 0, 0, 0, 0, "max_end");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r_f  = ($urandom_range(0, 99) == 0);
            r_sv = $urandom_range(0, 1) != 0;
            r_sz = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
            r_ds = $urandom_range(0, 1) != 0;
            r_dv = $urandom_range(0, 3) != 0;
            step(r_f, r_sv, r_sz, r_ds, r_dv, $sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
